// File: rtl/mtr_pkg.sv
// Shared definitions for the motor PWM driver.
// Holds the default PWM counter width, the per-channel state encoding,
// the speed/magnitude widths and the magnitude saturation helper.
package mtr_pkg;

  localparam int PWM_W_DEF = 11;
  localparam int SPD_W     = 12;
  localparam int MAG_W     = 11;

  localparam logic [MAG_W-1:0]        MAG_MAX = 11'd2047;
  localparam logic signed [SPD_W-1:0] SPD_MIN = 12'sh800;

  typedef enum logic {
    RUN  = 1'b0,
    DEAD = 1'b1
  } chan_state_t;

  // |spd| as an unsigned magnitude; the most negative code has no positive
  // twin in 12 bits, so it saturates to the largest duty instead of wrapping.
  function automatic logic [MAG_W-1:0] sat_mag(input logic signed [SPD_W-1:0] spd);
    logic signed [SPD_W-1:0] neg;
    neg = -spd;
    if (spd == SPD_MIN) begin
      return MAG_MAX;
    end else if (spd[SPD_W-1]) begin
      return neg[MAG_W-1:0];
    end else begin
      return spd[MAG_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mtr_chan.sv
// One H-bridge channel: sign-magnitude conversion of a speed command,
// period-synchronous duty shadow register, RUN/DEAD reversal FSM and the
// registered PWM compare.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   spd        - signed speed command
//   cnt        - shared free-running PWM counter
//   boundary   - high in the last count of a period (sample point)
//   force_off  - overspeed fault: pwm low, duty held 0, dir held
//   clear      - drive disabled: return to RUN, duty 0, dir 0
//   pwm, dir   - registered bridge outputs (dir 1 = reverse)
module mtr_chan
  import mtr_pkg::*;
#(
  parameter int PWM_W        = PWM_W_DEF,
  parameter int DEAD_PERIODS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [SPD_W-1:0] spd,
  input  logic [PWM_W-1:0]        cnt,
  input  logic                    boundary,
  input  logic                    force_off,
  input  logic                    clear,
  output logic                    pwm,
  output logic                    dir
);

  localparam int DCNT_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [DCNT_W-1:0] DEAD_LOAD = DCNT_W'(DEAD_PERIODS - 1);

  chan_state_t       state;
  logic [DCNT_W-1:0] dead_cnt;
  logic [PWM_W-1:0]  duty_p1;

  logic [MAG_W-1:0]  mag_p0;
  logic              sdir_p0;

  // ---- stage p0: combinational decode of the live command ----
  always_comb begin
    mag_p0  = sat_mag(spd);
    sdir_p0 = spd[SPD_W-1];
  end

  // ---- stage p1: boundary-sampled duty/FSM, registered compare ----
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state    <= RUN;
      dead_cnt <= '0;
      duty_p1  <= '0;
      dir      <= 1'b0;
      pwm      <= 1'b0;
    end else begin
      // duty_p1 is already 0 in DEAD; the state term just makes the coast explicit.
      pwm <= (state == RUN) && !force_off && (cnt < duty_p1);

      if (boundary) begin
        case (state)
          RUN: begin
            if (mag_p0 == '0) begin
              duty_p1 <= '0;
            end else if (sdir_p0 == dir) begin
              duty_p1 <= force_off ? '0 : PWM_W'(mag_p0);
            end else begin
              // Reversal: coast first, dir flips only when leaving DEAD.
              state    <= DEAD;
              duty_p1  <= '0;
              dead_cnt <= DEAD_LOAD;
            end
          end
          DEAD: begin
            if (dead_cnt == '0) begin
              state <= RUN;
              if (!force_off && (mag_p0 != '0)) begin
                dir     <= sdir_p0;
                duty_p1 <= PWM_W'(mag_p0);
              end else begin
                duty_p1 <= '0;
              end
            end else begin
              dead_cnt <= dead_cnt - 1'b1;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: rtl/mtr_pwm_drv.sv
// Motor PWM driver: converts signed left/right speed commands into
// sign-magnitude PWM plus direction for two H-bridges, with a period
// strobe and a sticky persistent-overspeed fault that coasts both motors.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   lft_spd, rght_spd   - signed 12-bit speed commands
//   too_fast            - overspeed indication, sampled at period boundary
//   pwr_up              - drive enable; low coasts and clears state
//   lft_pwm, lft_dir    - left bridge PWM and direction (1 = reverse)
//   rght_pwm, rght_dir  - right bridge PWM and direction
//   fault               - sticky overspeed fault
//   period_strobe       - one-cycle pulse while the counter is 0
module mtr_pwm_drv
  import mtr_pkg::*;
#(
  parameter int PWM_W         = PWM_W_DEF,
  parameter int DEAD_PERIODS  = 1,
  parameter int FAULT_PERIODS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        too_fast,
  input  logic        pwr_up,
  output logic        lft_pwm,
  output logic        lft_dir,
  output logic        rght_pwm,
  output logic        rght_dir,
  output logic        fault,
  output logic        period_strobe
);

  localparam int FCNT_W = $clog2(FAULT_PERIODS + 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX  = FCNT_W'(FAULT_PERIODS);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FAULT_PERIODS - 1);

  logic [PWM_W-1:0]  cnt;
  logic [FCNT_W-1:0] fcnt;
  logic              boundary;
  logic              clear;

  assign boundary = (cnt == '1);
  assign clear    = !pwr_up;

  // ---- stage p0: free-running period counter and strobe ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      period_strobe <= 1'b0;
    end else begin
      cnt           <= cnt + 1'b1;
      period_strobe <= boundary;
    end
  end

  // ---- stage p1: overspeed run-length counter and sticky fault ----
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fcnt  <= '0;
      fault <= 1'b0;
    end else if (boundary) begin
      if (too_fast) begin
        if (fcnt != FCNT_MAX) begin
          fcnt <= fcnt + 1'b1;
        end
        // Set on the same boundary where the run length reaches the limit.
        if (fcnt >= FCNT_LAST) begin
          fault <= 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  mtr_chan #(
    .PWM_W       (PWM_W),
    .DEAD_PERIODS(DEAD_PERIODS)
  ) u_lft (
    .clk      (clk),
    .rst      (rst),
    .spd      ($signed(lft_spd)),
    .cnt      (cnt),
    .boundary (boundary),
    .force_off(fault),
    .clear    (clear),
    .pwm      (lft_pwm),
    .dir      (lft_dir)
  );

  mtr_chan #(
    .PWM_W       (PWM_W),
    .DEAD_PERIODS(DEAD_PERIODS)
  ) u_rght (
    .clk      (clk),
    .rst      (rst),
    .spd      ($signed(rght_spd)),
    .cnt      (cnt),
    .boundary (boundary),
    .force_off(fault),
    .clear    (clear),
    .pwm      (rght_pwm),
    .dir      (rght_dir)
  );

endmodule

// File: tb/tb_mtr_pwm_drv.sv
module tb_mtr_pwm_drv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwr_up = 1'b1;
  logic        too_fast = 1'b0;
  logic [11:0] lft_spd = '0;
  logic [11:0] rght_spd = '0;
  logic        lft_pwm, lft_dir, rght_pwm, rght_dir, fault, period_strobe;

  int total = 0;
  int bad = 0;
  int tb_cnt = 0;

  mtr_pwm_drv dut (
    .clk          (clk),
    .rst          (rst),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .too_fast     (too_fast),
    .pwr_up       (pwr_up),
    .lft_pwm      (lft_pwm),
    .lft_dir      (lft_dir),
    .rght_pwm     (rght_pwm),
    .rght_dir     (rght_dir),
    .fault        (fault),
    .period_strobe(period_strobe)
  );

  always #5 clk = ~clk;

  // Reference model of the PWM counter value during the current cycle.
  always @(posedge clk) tb_cnt <= rst ? 0 : (tb_cnt + 1) % 2048;

  typedef struct {
    logic [11:0] l;
    logic [11:0] r;
    int          hl;
    int          hr;
    logic        dl;
    logic        dr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic go_to(input int c);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (tb_cnt != c && n < 5000);
    if (tb_cnt != c) chk("go_to_timeout", tb_cnt, c);
  endtask

  // Observes one full PWM window (cnt=1 .. cnt=0 of the following period).
  // New speeds are applied at cnt=1000, mid-window, for the next sample.
  task automatic run_period(input logic [11:0] nl, input logic [11:0] nr,
                            output int hl, output int hr,
                            output logic dl, output logic dr,
                            output logic fl, output logic fr,
                            output int tog, output int strb_bad);
    logic pl, pr, pdl, pdr;
    if (tb_cnt != 1) go_to(1);
    hl = 0; hr = 0; tog = 0; strb_bad = 0;
    dl = lft_dir; dr = rght_dir; fl = lft_pwm; fr = rght_pwm;
    pl = lft_pwm; pr = rght_pwm; pdl = lft_dir; pdr = rght_dir;
    for (int i = 0; i < 2048; i++) begin
      if (i == 999) begin
        lft_spd  = nl;
        rght_spd = nr;
      end
      if (lft_pwm === 1'b1) hl++;
      if (rght_pwm === 1'b1) hr++;
      if ((lft_dir !== pdl) && (lft_pwm || pl)) tog++;
      if ((rght_dir !== pdr) && (rght_pwm || pr)) tog++;
      if (period_strobe !== (i == 2047)) strb_bad++;
      pl = lft_pwm; pr = rght_pwm; pdl = lft_dir; pdr = rght_dir;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int hl, hr, tog, sb, nk, cnt_hi;
    logic dl, dr, fl, fr;

    vecs[0] = '{12'd512,  12'd0,   512,  0,    1'b0, 1'b0};
    vecs[1] = '{12'd2047, 12'd1,   2047, 1,    1'b0, 1'b0};
    vecs[2] = '{12'd0,    12'd100, 0,    100,  1'b0, 1'b0};
    vecs[3] = '{12'd300,  12'd100, 300,  100,  1'b0, 1'b0};
    vecs[4] = '{12'hED4,  12'd100, 0,    100,  1'b0, 1'b0};
    vecs[5] = '{12'hED4,  12'h800, 300,  0,    1'b1, 1'b0};
    vecs[6] = '{12'h800,  12'h800, 2047, 2047, 1'b1, 1'b1};
    vecs[7] = '{12'h800,  12'd0,   2047, 0,    1'b1, 1'b1};
    vecs[8] = '{12'hFFB,  12'hFFF, 5,    1,    1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_lft_pwm", lft_pwm, 0);
    chk("rst_rght_pwm", rght_pwm, 0);
    chk("rst_lft_dir", lft_dir, 0);
    chk("rst_rght_dir", rght_dir, 0);
    chk("rst_fault", fault, 0);
    chk("rst_strobe", period_strobe, 0);
    rst = 1'b0;

    go_to(2000);
    lft_spd  = vecs[0].l;
    rght_spd = vecs[0].r;
    for (int k = 0; k < 9; k++) begin
      nk = (k < 8) ? k + 1 : 8;
      run_period(vecs[nk].l, vecs[nk].r, hl, hr, dl, dr, fl, fr, tog, sb);
      chk($sformatf("v%0d_lft_high", k), hl, vecs[k].hl);
      chk($sformatf("v%0d_rght_high", k), hr, vecs[k].hr);
      chk($sformatf("v%0d_lft_dir", k), dl, vecs[k].dl);
      chk($sformatf("v%0d_rght_dir", k), dr, vecs[k].dr);
      chk($sformatf("v%0d_lft_first", k), fl, (vecs[k].hl > 0));
      chk($sformatf("v%0d_rght_first", k), fr, (vecs[k].hr > 0));
      chk($sformatf("v%0d_dir_toggle_hi", k), tog, 0);
      chk($sformatf("v%0d_strobe", k), sb, 0);
    end

    // Three overspeed boundaries then a quiet one: no fault.
    go_to(2000);
    too_fast = 1'b1;
    repeat (3) go_to(2000);
    too_fast = 1'b0;
    go_to(5);
    chk("fault_after_3", fault, 0);
    // Four consecutive overspeed boundaries: fault on the 4th.
    go_to(2000);
    too_fast = 1'b1;
    repeat (3) go_to(2000);
    chk("fault_before_4th", fault, 0);
    go_to(0);
    chk("fault_after_4th", fault, 1);
    too_fast = 1'b0;
    lft_spd  = 12'd1000;
    rght_spd = 12'd1000;
    run_period(12'd1000, 12'd1000, hl, hr, dl, dr, fl, fr, tog, sb);
    chk("fault_lft_high", hl, 0);
    chk("fault_rght_high", hr, 0);
    chk("fault_sticky", fault, 1);

    // Both channels are now coasting in DEAD under the fault; pulse pwr_up low.
    go_to(700);
    pwr_up = 1'b0;
    @(posedge clk);
    #1;
    pwr_up = 1'b1;
    chk("pwr_fault", fault, 0);
    chk("pwr_lft_dir", lft_dir, 0);
    chk("pwr_rght_dir", rght_dir, 0);
    chk("pwr_lft_pwm", lft_pwm, 0);
    run_period(12'd1000, 12'd1000, hl, hr, dl, dr, fl, fr, tog, sb);
    chk("pwr_resume_lft_high", hl, 1000);
    chk("pwr_resume_rght_high", hr, 1000);
    chk("pwr_resume_lft_dir", dl, 0);
    chk("pwr_resume_rght_dir", dr, 0);

    // Mid-period reset while pwm is high.
    go_to(700);
    chk("pre_rst_lft_pwm", lft_pwm, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_lft_pwm", lft_pwm, 0);
    chk("midrst_rght_pwm", rght_pwm, 0);
    chk("midrst_fault", fault, 0);
    chk("midrst_strobe", period_strobe, 0);
    cnt_hi = 0;
    for (int n = 0; n < 3000 && tb_cnt != 2047; n++) begin
      if (lft_pwm !== 1'b0 || period_strobe !== 1'b0) cnt_hi++;
      @(posedge clk);
      #1;
    end
    chk("midrst_first_period_quiet", cnt_hi, 0);
    chk("midrst_strobe_before_wrap", period_strobe, 0);
    @(posedge clk);
    #1;
    chk("midrst_strobe_at_wrap", period_strobe, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
